// File: rtl/pattern_fb_pkg.sv
// Shared types and the per-pixel pattern generator for the double-buffered pattern frame buffer.
package pattern_fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WAIT_SWAP
    } state_e;

    typedef enum logic [1:0] {
        RAINBOW,
        XGRAD,
        CHECKER,
        SOLID
    } mode_e;

    // Works on 32-bit operands; the caller truncates the result to its pixel width.
    function automatic logic [31:0] pattern_pixel(
        input mode_e       mode,
        input logic [31:0] x_off,
        input logic [31:0] y,
        input logic [31:0] count,
        input int unsigned check_shift,
        input logic [31:0] solid
    );
        logic [31:0] pix;
        logic [31:0] xs;
        logic [31:0] ys;
        pix = '0;
        xs  = x_off >> check_shift;
        ys  = y >> check_shift;
        case (mode)
            RAINBOW: pix = count;
            XGRAD:   pix = x_off;
            CHECKER: pix = (xs[0] ^ ys[0]) ? '1 : '0;
            default: pix = solid;
        endcase
        return pix;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a registered output.
module fb_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    // NOTE: the array is deliberately not reset so it can map onto block RAM; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The output register holds its value when no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pattern_framebuffer.sv
// Double-buffered test-pattern frame buffer: writer FSM fills the back bank, reader streams the front bank.
// Define PATTERN_ANIMATE_EN to build the per-frame offset register so patterns scroll by one per frame.
module pattern_framebuffer
    import pattern_fb_pkg::*;
#(
    parameter int               H_RES       = 640,
    parameter int               V_RES       = 480,
    parameter int               X_W         = 10,
    parameter int               Y_W         = 10,
    parameter int               PIX_W       = 15,
    parameter int               CHECK_SHIFT = 3,
    parameter logic [PIX_W-1:0] SOLID_COLOR = 15'h7FFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rd_en,
    output logic [PIX_W-1:0] pix_out,
    output logic             rd_valid,
    output logic             frame_done,
    output logic             front_valid,
    output logic             busy
);

    localparam int ADDR_W = 1 + X_W + Y_W;
    localparam int OFF_W  = (PIX_W > X_W) ? PIX_W : X_W;

    state_e           state;
    mode_e            mode_q;
    logic [X_W-1:0]   wx;
    logic [Y_W-1:0]   wy;
    logic [X_W-1:0]   rx;
    logic [Y_W-1:0]   ry;
    logic             wr_bank;
    logic [PIX_W-1:0] count;
    logic [OFF_W-1:0] offset;
    logic [OFF_W-1:0] offset_next;

    logic             wr_last_x;
    logic             wr_last_y;
    logic             rd_last_x;
    logic             rd_last_y;
    logic             swap;
    logic             wr_fire;
    logic             rd_fire;
    logic             rd_bank;
    logic [PIX_W-1:0] wdata;

    assign wr_last_x = (wx == X_W'(H_RES - 1));
    assign wr_last_y = (wy == Y_W'(V_RES - 1));
    assign rd_last_x = (rx == X_W'(H_RES - 1));
    assign rd_last_y = (ry == Y_W'(V_RES - 1));

    assign swap    = (state == WAIT_SWAP) && (rx == '0) && (ry == '0);
    assign wr_fire = (state == FILL) && en;
    assign rd_fire = rd_en && front_valid;
    // A read issued in the swap cycle already targets the bank that is becoming the front.
    assign rd_bank = swap ? wr_bank : ~wr_bank;

`ifdef PATTERN_ANIMATE_EN
    logic [OFF_W-1:0] offset_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            offset_q <= '0;
        end else if (swap) begin
            offset_q <= offset_q + OFF_W'(1);
        end
    end

    assign offset      = offset_q;
    assign offset_next = offset_q + OFF_W'(1);
`else
    assign offset      = '0;
    assign offset_next = '0;
`endif

    assign wdata = PIX_W'(pattern_pixel(mode_q, 32'(wx) + 32'(offset), 32'(wy), 32'(count),
                                        CHECK_SHIFT, 32'(SOLID_COLOR)));

    // Writer FSM; busy, frame_done and front_valid are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= RAINBOW;
            wx          <= '0;
            wy          <= '0;
            wr_bank     <= 1'b0;
            count       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            front_valid <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        mode_q <= mode_e'(mode);
                        count  <= PIX_W'(offset);
                        state  <= FILL;
                        busy   <= 1'b1;
                    end
                end
                FILL: begin
                    if (en) begin
                        count <= count + 1'b1;
                        if (wr_last_x) begin
                            wx <= '0;
                            if (wr_last_y) begin
                                wy    <= '0;
                                state <= WAIT_SWAP;
                                busy  <= 1'b0;
                            end else begin
                                wy <= wy + 1'b1;
                            end
                        end else begin
                            wx <= wx + 1'b1;
                        end
                    end
                end
                WAIT_SWAP: begin
                    if (swap) begin
                        wr_bank     <= ~wr_bank;
                        front_valid <= 1'b1;
                        frame_done  <= 1'b1;
                        wx          <= '0;
                        wy          <= '0;
                        mode_q      <= mode_e'(mode);
                        count       <= PIX_W'(offset_next);
                        state       <= FILL;
                        busy        <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Reader position walks the front bank in raster order, one pixel per granted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx       <= '0;
            ry       <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                if (rd_last_x) begin
                    rx <= '0;
                    ry <= rd_last_y ? '0 : ry + 1'b1;
                end else begin
                    rx <= rx + 1'b1;
                end
            end
        end
    end

    fb_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PIX_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .waddr ({wr_bank, wy, wx}),
        .wdata (wdata),
        .re    (rd_fire),
        .raddr ({rd_bank, ry, rx}),
        .rdata (pix_out)
    );

endmodule

// File: tb/tb_pattern_framebuffer.sv
// Scoreboard bench for pattern_framebuffer on a 4x2 frame of 8-bit pixels.
module tb_pattern_framebuffer;

    localparam int         H_RES       = 4;
    localparam int         V_RES       = 2;
    localparam int         X_W         = 2;
    localparam int         Y_W         = 1;
    localparam int         PIX_W       = 8;
    localparam int         CHECK_SHIFT = 0;
    localparam logic [7:0] SOLID       = 8'hA5;
`ifdef PATTERN_ANIMATE_EN
    localparam int ANIM = 1;
`else
    localparam int ANIM = 0;
`endif

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic       rd_en = 1'b0;
    logic [1:0] mode  = 2'd0;
    logic [7:0] pix_out;
    logic       rd_valid;
    logic       frame_done;
    logic       front_valid;
    logic       busy;

    typedef struct {
        logic [7:0] pix;
        bit         first;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   chk_fd   = 1'b0;
    int   fd_seen  = 0;

    always #5 clk = ~clk;

    pattern_framebuffer #(
        .H_RES       (H_RES),
        .V_RES       (V_RES),
        .X_W         (X_W),
        .Y_W         (Y_W),
        .PIX_W       (PIX_W),
        .CHECK_SHIFT (CHECK_SHIFT),
        .SOLID_COLOR (SOLID)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .rd_en       (rd_en),
        .pix_out     (pix_out),
        .rd_valid    (rd_valid),
        .frame_done  (frame_done),
        .front_valid (front_valid),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one read in the next cycle and queue its expected pixel.
    task automatic expect_read(input logic [7:0] p, input bit first);
        exp_t e;
        e.pix   = p;
        e.first = first;
        sb.push_back(e);
        rd_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en    = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Start from IDLE, fill one frame and freeze the writer right after the swap.
    task automatic fill_frame(input logic [1:0] m);
        int t;
        mode = m;
        en   = 1'b1;
        t    = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!frame_done && t < 40);
        check("fill_frame_done", frame_done, 1);
        en = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pixel.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rd_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_rd_valid", rd_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("pix_out", pix_out, e.pix);
                    if (chk_fd && frame_done) begin
                        fd_seen++;
                        check("frame_done_at_first_pixel", e.first, 1);
                    end
                end
            end else if (!rst && chk_fd && frame_done) begin
                check("frame_done_with_read", rd_valid, 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         busy_cnt;
        int         fd_cnt;
        int         fd_at;
        int         fd_idx;
        int         rdv;
        int         k;
        logic [7:0] chk_seq [8];
        bit         en_pat  [4];

        chk_seq = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
        en_pat  = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset values, then a mode-0 fill with reads idle.
        repeat (2) @(negedge clk);
        check("rst_pix_out", pix_out, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_front_valid", front_valid, 0);
        check("rst_busy", busy, 0);
        rst      = 1'b0;
        mode     = 2'd0;
        en       = 1'b1;
        busy_cnt = 0;
        fd_cnt   = 0;
        fd_at    = 0;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i <= 9 && busy) busy_cnt++;
            if (frame_done) begin
                fd_cnt++;
                fd_at = i;
            end
            if (i == 10) en = 1'b0;
        end
        check("t1_busy_cycles", busy_cnt, 8);
        check("t1_frame_done_count", fd_cnt, 1);
        check("t1_frame_done_cycle", fd_at, 10);
        check("t1_front_valid", front_valid, 1);
        check("t1_busy_refill", busy, 1);

        // Two passes over the front frame: the ninth read wraps to 00.
        for (int i = 0; i < 16; i++) expect_read(8'(i % 8), (i % 8) == 0);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check("t2_drain", sb.size(), 0);

        // Checker with 1-pixel squares.
        do_reset();
        fill_frame(2'd2);
        for (int i = 0; i < 8; i++) expect_read(chk_seq[i], i == 0);
        rd_en = 1'b0;

        // X gradient with en toggling 1,0,0,1 during the fill.
        do_reset();
        mode   = 2'd1;
        en     = 1'b1;
        fd_idx = -1;
        @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            en = en_pat[i % 4];
            @(negedge clk);
            if (i == 1) check("t4_busy_while_held", busy, 1);
            if (frame_done) begin
                fd_idx = i;
                break;
            end
        end
        en = 1'b0;
        check("t4_frame_done_cycle", fd_idx, 16);
        for (int i = 0; i < 8; i++) expect_read(8'(i % 4), i == 0);
        rd_en = 1'b0;

        // Continuous reads across swaps: frames 1, 2, 2 (repeat), 3.
        do_reset();
        fill_frame(2'd0);
        @(negedge clk);
        chk_fd  = 1'b1;
        fd_seen = 0;
        en      = 1'b1;
        for (int i = 0; i < 32; i++) begin
            k = (i < 8) ? 1 : ((i < 24) ? 2 : 3);
            expect_read(8'((k - 1) * ANIM + (i % 8)), (i % 8) == 0);
        end
        en    = 1'b0;
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk_fd = 1'b0;
        check("t5_frame_done_count", fd_seen, 2);
        check("t5_drain", sb.size(), 0);

        // Reset in the middle of a fill at (2,0).
        do_reset();
        fill_frame(2'd1);
        for (int i = 0; i < 4; i++) expect_read(8'(i), i == 0);
        rd_en = 1'b0;
        en    = 1'b1;
        repeat (2) @(negedge clk);
        check("t6_pix_held", pix_out, 3);
        check("t6_busy_mid_fill", busy, 1);
        rst = 1'b1;
        #1;
        check("t6_rst_pix_out", pix_out, 0);
        check("t6_rst_rd_valid", rd_valid, 0);
        check("t6_rst_frame_done", frame_done, 0);
        check("t6_rst_front_valid", front_valid, 0);
        check("t6_rst_busy", busy, 0);
        en = 1'b0;
        @(negedge clk);
        rst   = 1'b0;
        rd_en = 1'b1;
        rdv   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_valid) rdv++;
        end
        rd_en = 1'b0;
        check("t6_no_reads_before_frame", rdv, 0);
        check("t6_front_invalid", front_valid, 0);
        fill_frame(2'd1);
        for (int i = 0; i < 8; i++) expect_read(8'(i % 4), i == 0);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        check("final_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
